// File: rtl/rvfi_regfile_check.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_regfile_check
// Description : Shadows tracked architectural registers from RVFI retire
//               traffic and checks the source operands of one instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_regfile_check #(
    parameter int XLEN   = 32,
    parameter int NRET   = 2,
    parameter int NTRACK = 2,
    parameter int CHK_X0 = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 check,
    input  logic [1:0]           check_chan,
    input  logic [63:0]          insn_order,
    input  logic [5*NTRACK-1:0]  track_idx,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [NRET-1:0]      rvfi_trap,
    input  logic [64*NRET-1:0]   rvfi_order,
    input  logic [5*NRET-1:0]    rvfi_rd_addr,
    input  logic [5*NRET-1:0]    rvfi_rs1_addr,
    input  logic [5*NRET-1:0]    rvfi_rs2_addr,
    input  logic [XLEN*NRET-1:0] rvfi_rd_wdata,
    input  logic [XLEN*NRET-1:0] rvfi_rs1_rdata,
    input  logic [XLEN*NRET-1:0] rvfi_rs2_rdata,
    output logic [NTRACK-1:0]    written,
    output logic                 done,
    output logic                 err,
    output logic [2:0]           err_code
);
    localparam logic       c_CHK_X0  = (CHK_X0 != 0);
    localparam logic [2:0] c_NRET    = 3'(NRET);
    localparam logic [2:0] c_ERR_RS1 = 3'd1;
    localparam logic [2:0] c_ERR_RS2 = 3'd2;
    localparam logic [2:0] c_ERR_X0  = 3'd3;
    localparam logic [2:0] c_ERR_CTL = 3'd4;
    localparam logic [2:0] c_ERR_CH  = 3'd5;

    typedef enum logic [0:0] {COLLECT = 1'b0, DONE = 1'b1} state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_shadow [NTRACK];
    logic [NTRACK-1:0] r_written;
    logic              r_err;
    logic [2:0]        r_err_code;

    logic [63:0]       w_ord  [NRET];
    logic [4:0]        w_rd   [NRET];
    logic [XLEN-1:0]   w_wd   [NRET];
    logic [4:0]        w_tidx [NTRACK];
    logic [NTRACK-1:0] w_x0_slot;

    always_comb begin
        for (int c = 0; c < NRET; c++) begin
            w_ord[c] = rvfi_order[c*64 +: 64];
            w_rd[c]  = rvfi_rd_addr[c*5 +: 5];
            w_wd[c]  = rvfi_rd_wdata[c*XLEN +: XLEN];
        end
        for (int s = 0; s < NTRACK; s++) begin
            w_tidx[s]    = track_idx[s*5 +: 5];
            w_x0_slot[s] = c_CHK_X0 && (w_tidx[s] == 5'd0);
        end
    end

    logic w_collect;
    logic w_chk;
    logic w_chan_ok;
    assign w_collect = (r_state == COLLECT);
    assign w_chk     = check && w_collect;
    assign w_chan_ok = ({1'b0, check_chan} < c_NRET);

    // A channel may feed a shadow if it retired cleanly before the instruction
    // under test; the checked channel itself never feeds on the check cycle.
    logic [NRET-1:0] w_cand;
    logic            w_x0_bad;
    always_comb begin
        w_x0_bad = 1'b0;
        for (int c = 0; c < NRET; c++) begin
            w_cand[c] = w_collect && rvfi_valid[c] && !rvfi_trap[c] &&
                        (w_ord[c] < insn_order) &&
                        !(w_chk && (2'(c) == check_chan));
            if (c_CHK_X0 && w_collect && rvfi_valid[c] && !rvfi_trap[c] &&
                (w_rd[c] == 5'd0) && (w_wd[c] != '0))
                w_x0_bad = 1'b1;
        end
    end

    // Per slot, the youngest qualifying write of the cycle wins on order alone.
    logic [NTRACK-1:0] w_upd;
    logic [63:0]       w_best_ord [NTRACK];
    logic [XLEN-1:0]   w_upd_data [NTRACK];
    logic [NTRACK-1:0] w_eff_wr;
    logic [XLEN-1:0]   w_eff_val  [NTRACK];
    always_comb begin
        for (int s = 0; s < NTRACK; s++) begin
            w_upd[s]      = 1'b0;
            w_best_ord[s] = '0;
            w_upd_data[s] = '0;
            for (int c = 0; c < NRET; c++) begin
                if (w_cand[c] && !w_x0_slot[s] && (w_rd[c] == w_tidx[s]) &&
                    (!w_upd[s] || (w_ord[c] > w_best_ord[s]))) begin
                    w_upd[s]      = 1'b1;
                    w_best_ord[s] = w_ord[c];
                    w_upd_data[s] = w_wd[c];
                end
            end
            w_eff_wr[s]  = r_written[s] | w_upd[s] | w_x0_slot[s];
            w_eff_val[s] = w_upd[s] ? w_upd_data[s] : r_shadow[s];
        end
    end

    logic            w_sel_valid;
    logic [63:0]     w_sel_ord;
    logic [4:0]      w_sel_rs1;
    logic [4:0]      w_sel_rs2;
    logic [XLEN-1:0] w_sel_r1d;
    logic [XLEN-1:0] w_sel_r2d;
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_ord   = '0;
        w_sel_rs1   = '0;
        w_sel_rs2   = '0;
        w_sel_r1d   = '0;
        w_sel_r2d   = '0;
        for (int c = 0; c < NRET; c++) begin
            if (2'(c) == check_chan) begin
                w_sel_valid = rvfi_valid[c];
                w_sel_ord   = w_ord[c];
                w_sel_rs1   = rvfi_rs1_addr[c*5 +: 5];
                w_sel_rs2   = rvfi_rs2_addr[c*5 +: 5];
                w_sel_r1d   = rvfi_rs1_rdata[c*XLEN +: XLEN];
                w_sel_r2d   = rvfi_rs2_rdata[c*XLEN +: XLEN];
            end
        end
    end

    logic       w_rs1_bad;
    logic       w_rs2_bad;
    logic       w_ctl_bad;
    logic       w_ch_bad;
    logic [2:0] w_err_code;
    always_comb begin
        w_rs1_bad = 1'b0;
        w_rs2_bad = 1'b0;
        for (int s = 0; s < NTRACK; s++) begin
            if (w_chk && w_chan_ok && w_eff_wr[s]) begin
                if ((w_sel_rs1 == w_tidx[s]) && (w_sel_r1d != w_eff_val[s]))
                    w_rs1_bad = 1'b1;
                if ((w_sel_rs2 == w_tidx[s]) && (w_sel_r2d != w_eff_val[s]))
                    w_rs2_bad = 1'b1;
            end
        end
        w_ctl_bad = w_chk && w_chan_ok && (!w_sel_valid || (w_sel_ord != insn_order));
        w_ch_bad  = w_chk && !w_chan_ok;
        if (w_rs1_bad)      w_err_code = c_ERR_RS1;
        else if (w_rs2_bad) w_err_code = c_ERR_RS2;
        else if (w_x0_bad)  w_err_code = c_ERR_X0;
        else if (w_ctl_bad) w_err_code = c_ERR_CTL;
        else if (w_ch_bad)  w_err_code = c_ERR_CH;
        else                w_err_code = 3'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= COLLECT;
            r_written  <= '0;
            r_err      <= 1'b0;
            r_err_code <= 3'd0;
            for (int s = 0; s < NTRACK; s++) r_shadow[s] <= '0;
        end else if (r_state == COLLECT) begin
            if (check) r_state <= DONE;
            for (int s = 0; s < NTRACK; s++) begin
                if (w_upd[s]) begin
                    r_shadow[s]  <= w_upd_data[s];
                    r_written[s] <= 1'b1;
                end
            end
            // Sticky: only the first detected code is kept.
            if (!r_err && (w_err_code != 3'd0)) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
        end
    end

    assign written  = r_written | w_x0_slot;
    assign done     = (r_state == DONE);
    assign err      = r_err;
    assign err_code = r_err_code;

endmodule
`default_nettype wire
